// File: rtl/pan_tompkins_pkg.sv
// Shared definitions for the Pan-Tompkins QRS detector stages.
package pan_tompkins_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 11;
    localparam int unsigned MWI_WINDOW     = 32;

    // Running-sum width: enough headroom for WINDOW full-scale samples.
    function automatic int unsigned mwi_sum_w(input int unsigned dw, input int unsigned win);
        return dw + $clog2(win);
    endfunction

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/mwi_delay_line.sv
// Circular sample buffer for the moving-window integrator.
// Presents the oldest entry (the one about to be overwritten) combinationally.
module mwi_delay_line #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned WINDOW     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_oldest_c
);

    localparam int unsigned PTR_W = $clog2(WINDOW);

    logic [DATA_WIDTH-1:0] r_buf [WINDOW];
    logic [PTR_W-1:0]      r_wr_ptr;

    assign o_oldest_c = r_buf[r_wr_ptr];

    // Buffer write and pointer advance; WINDOW is a power of two so the pointer wraps naturally.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned i = 0; i < WINDOW; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_buf[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/moving_window_integrator.sv
// Moving-window integrator: running sum and average of the last WINDOW samples.
// Optional macro MWI_WARMUP_EN: hold off out_valid until the window has filled.
module moving_window_integrator
    import pan_tompkins_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned WINDOW     = MWI_WINDOW
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clr,
    input  logic                                      in_valid,
    input  logic [DATA_WIDTH-1:0]                     data,
    output logic [DATA_WIDTH-1:0]                     out,
    output logic [mwi_sum_w(DATA_WIDTH, WINDOW)-1:0]  sum,
    output logic                                      out_valid
);

    localparam int unsigned LOG2W = $clog2(WINDOW);
    localparam int unsigned SUM_W = mwi_sum_w(DATA_WIDTH, WINDOW);

    logic [DATA_WIDTH-1:0] w_oldest;
    logic                  w_accept;
    logic                  w_emit;
    logic [SUM_W-1:0]      w_sum_nxt;

    logic [SUM_W-1:0]      r_sum;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_out_valid;

    // clr wins over a concurrent sample; rst is handled by every register directly.
    assign w_accept  = in_valid & ~clr;

    // Sum always equals the buffer contents, so this can neither wrap nor underflow.
    assign w_sum_nxt = r_sum + SUM_W'(data) - SUM_W'(w_oldest);

    mwi_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .WINDOW     (WINDOW)
    ) u_delay_line (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .i_wr_en    (w_accept),
        .i_data     (data),
        .o_oldest_c (w_oldest)
    );

`ifdef MWI_WARMUP_EN
    localparam int unsigned FILL_W = LOG2W + 1;

    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_fill_nxt;

    assign w_fill_nxt = (r_fill == FILL_W'(WINDOW)) ? r_fill : r_fill + FILL_W'(1);
    assign w_emit     = w_accept & (w_fill_nxt == FILL_W'(WINDOW));

    // Fill counter, saturating once the window holds WINDOW real samples.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_fill <= '0;
        end else if (w_accept) begin
            r_fill <= w_fill_nxt;
        end
    end
`else
    // Buffer starts zero-filled, so every accepted sample yields a valid (ramping) average.
    assign w_emit = w_accept;
`endif

    // Output registers: sum/out hold between samples, out_valid is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sum       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            if (w_accept) begin
                r_sum <= w_sum_nxt;
                r_out <= w_sum_nxt[SUM_W-1:LOG2W];
            end
        end
    end

    assign out       = r_out;
    assign sum       = r_sum;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_moving_window_integrator.sv
// Scoreboard bench for moving_window_integrator (DATA_WIDTH=11, WINDOW=32).
module tb_moving_window_integrator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [10:0] data;
    logic [10:0] out;
    logic [15:0] sum;
    logic        out_valid;

    typedef struct packed {
        logic [15:0] sum;
        logic [10:0] out;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   passed    = 0;
    int   since_clr = 0;

    always #5 clk = ~clk;

    moving_window_integrator dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .data      (data),
        .out       (out),
        .sum       (sum),
        .out_valid (out_valid)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int unsigned s);
        exp_t e;
        e.sum = 16'(s);
        e.out = 11'(s >> 5);
        q.push_back(e);
    endtask

    // Drive one sample for one cycle; expected sum is hand-computed by the caller.
    task automatic send(input int unsigned x, input int unsigned exp_sum);
        in_valid = 1'b1;
        data     = 11'(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        since_clr++;
`ifdef MWI_WARMUP_EN
        if (since_clr >= 32) push(exp_sum);
`else
        push(exp_sum);
`endif
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flush();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        since_clr = 0;
    endtask

    // Monitor: every out_valid strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL spurious_valid: out_valid=1 sum=%0d with no expected output at %0t", sum, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("out", 32'(out), 32'(e.out));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        data     = '0;

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("idle_sum", 32'(sum), 0);
            check("idle_out", 32'(out), 0);
            check("idle_valid", 32'(out_valid), 0);
        end

        // Step: 40 samples of 64
        for (int k = 1; k <= 40; k++) send(64, 64 * ((k < 32) ? k : 32));
        idle(3);
        check("step_hold_sum", 32'(sum), 2048);
        check("step_hold_out", 32'(out), 64);
        flush();

        // Impulse: 1023 then 32 zeros
        send(1023, 1023);
        for (int k = 1; k <= 31; k++) send(0, 1023);
        send(0, 0);
        idle(2);
        flush();

        // Full scale: 64 x 2047, then ramp down to 0
        for (int k = 1; k <= 64; k++) send(2047, 2047 * ((k < 32) ? k : 32));
        for (int k = 1; k <= 32; k++) send(0, 2047 * (32 - k));
        idle(2);
        flush();

        // Step with random gaps, then clr concurrent with a valid sample
        for (int k = 1; k <= 10; k++) begin
            idle($urandom_range(0, 5));
            send(64, 64 * k);
        end
        idle(2);
        check("gap_sum10", 32'(sum), 640);
        clr      = 1'b1;
        in_valid = 1'b1;
        data     = 11'd64;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        since_clr = 0;
        check("clr_sum", 32'(sum), 0);
        check("clr_out", 32'(out), 0);
        check("clr_valid", 32'(out_valid), 0);
        send(64, 64);
        idle(2);

        // rst with a sample in flight: no update, everything cleared
        rst      = 1'b1;
        in_valid = 1'b1;
        data     = 11'd500;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        since_clr = 0;
        check("rst_sum", 32'(sum), 0);
        check("rst_valid", 32'(out_valid), 0);
        send(7, 7);
        idle(2);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected outputs never seen, required 0", q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
